// File: rtl/sdram_bridge_pkg.sv
// Shared types and constants for the Wishbone-to-SDRAM-controller bridge.
package sdram_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    MERGE   = 3'd3,
    WR_REQ  = 3'd4,
    ACK     = 3'd5
  } state_e;

  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

  // Address bits at and above this position select the bridge window.
  localparam int WIN_LSB = 25;

  function automatic logic win_hit(input logic [31:0] adr, input logic [31:0] base);
    return adr[31:WIN_LSB] == base[31:WIN_LSB];
  endfunction

endpackage

// File: rtl/wb_byte_merge.sv
// Per-byte-lane select between write data and previously read data.
module wb_byte_merge (
  input  logic [31:0] i_rd_data,
  input  logic [31:0] i_wr_data,
  input  logic [3:0]  i_sel,
  output logic [31:0] o_data
);

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign o_data[8*i +: 8] = i_sel[i] ? i_wr_data[8*i +: 8] : i_rd_data[8*i +: 8];
  end

endmodule

// File: rtl/wb_sdram_bridge.sv
// Wishbone slave that turns windowed bus cycles into single-word SDRAM
// controller requests; partial writes go through read-modify-write and
// every read is bounded by a watchdog.
module wb_sdram_bridge
  import sdram_bridge_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3800_0000,
  parameter int          TIMEOUT   = 1023,
  parameter logic [31:0] ERR_DATA  = ERR_DATA_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        sd_in_valid,
  output logic        sd_rw,
  output logic [22:0] sd_addr,
  output logic [31:0] sd_data_in,
  input  logic        sd_busy,
  input  logic        sd_out_valid,
  input  logic [31:0] sd_data_out,
  output logic        err_o
);

  localparam logic [9:0] TO_VAL = 10'(TIMEOUT);

  state_e      r_state, w_state_nxt;
  logic        r_we, w_we_nxt;
  logic [3:0]  r_sel, w_sel_nxt;
  logic [31:0] r_wr_data, w_wr_data_nxt;
  logic [31:0] r_rd_data, w_rd_data_nxt;
  logic [9:0]  r_cnt, w_cnt_nxt;
  logic        r_ack, w_ack_nxt;
  logic [31:0] r_dat_o, w_dat_o_nxt;
  logic        r_in_valid, w_in_valid_nxt;
  logic        r_rw, w_rw_nxt;
  logic [22:0] r_addr, w_addr_nxt;
  logic [31:0] r_data_in, w_data_in_nxt;
  logic        r_err, w_err_nxt;

  logic        w_req, w_full_wr, w_null_wr, w_timeout, w_idle;
  logic [9:0]  w_cnt_inc;
  logic [31:0] w_mrg_rd, w_mrg_wr, w_merged;
  logic [3:0]  w_mrg_sel;
  logic        w_unused;

  assign w_unused  = ^wbs_adr_i[1:0];
  assign w_req     = wbs_cyc_i & wbs_stb_i & win_hit(wbs_adr_i, BASE_ADDR) & ~r_ack;
  assign w_full_wr = wbs_we_i & (wbs_sel_i == 4'hF);
  assign w_null_wr = wbs_we_i & (wbs_sel_i == 4'h0);
  assign w_cnt_inc = r_cnt + 10'd1;
  assign w_timeout = (w_cnt_inc == TO_VAL);
  assign w_idle    = (r_state == IDLE);

  // In IDLE the merger passes a full write straight through; later it
  // overlays the latched write bytes on the data read back.
  assign w_mrg_rd  = w_idle ? 32'h0 : r_rd_data;
  assign w_mrg_wr  = w_idle ? wbs_dat_i : r_wr_data;
  assign w_mrg_sel = w_idle ? 4'hF : r_sel;

  wb_byte_merge u_merge (
    .i_rd_data (w_mrg_rd),
    .i_wr_data (w_mrg_wr),
    .i_sel     (w_mrg_sel),
    .o_data    (w_merged)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_req) w_state_nxt = w_full_wr ? WR_REQ : (w_null_wr ? ACK : RD_REQ);
      RD_REQ:  if (!sd_busy) w_state_nxt = RD_WAIT;
      RD_WAIT: if (sd_out_valid) w_state_nxt = r_we ? MERGE : ACK;
               else if (w_timeout) w_state_nxt = ACK;
      MERGE:   w_state_nxt = WR_REQ;
      WR_REQ:  if (!sd_busy) w_state_nxt = ACK;
      ACK:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath
  always_comb begin
    w_we_nxt       = r_we;
    w_sel_nxt      = r_sel;
    w_wr_data_nxt  = r_wr_data;
    w_rd_data_nxt  = r_rd_data;
    w_cnt_nxt      = r_cnt;
    w_ack_nxt      = 1'b0;
    w_dat_o_nxt    = r_dat_o;
    w_in_valid_nxt = 1'b0;
    w_rw_nxt       = r_rw;
    w_addr_nxt     = r_addr;
    w_data_in_nxt  = r_data_in;
    w_err_nxt      = r_err;
    unique case (r_state)
      IDLE: if (w_req) begin
        w_we_nxt      = wbs_we_i;
        w_sel_nxt     = wbs_sel_i;
        w_wr_data_nxt = wbs_dat_i;
        w_addr_nxt    = wbs_adr_i[24:2];
        if (w_full_wr) w_data_in_nxt = w_merged;
      end
      RD_REQ: if (!sd_busy) begin
        w_in_valid_nxt = 1'b1;
        w_rw_nxt       = 1'b0;
        w_cnt_nxt      = 10'd0;
      end
      RD_WAIT: begin
        w_cnt_nxt = w_cnt_inc;
        if (sd_out_valid) begin
          w_rd_data_nxt = sd_data_out;
          if (!r_we) w_dat_o_nxt = sd_data_out;
        end else if (w_timeout) begin
          w_err_nxt   = 1'b1;
          w_dat_o_nxt = ERR_DATA;
        end
      end
      MERGE: w_data_in_nxt = w_merged;
      WR_REQ: if (!sd_busy) begin
        w_in_valid_nxt = 1'b1;
        w_rw_nxt       = 1'b1;
      end
      ACK: w_ack_nxt = wbs_cyc_i;
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_we       <= 1'b0;
      r_sel      <= 4'h0;
      r_wr_data  <= 32'h0;
      r_rd_data  <= 32'h0;
      r_cnt      <= 10'd0;
      r_ack      <= 1'b0;
      r_dat_o    <= 32'h0;
      r_in_valid <= 1'b0;
      r_rw       <= 1'b0;
      r_addr     <= 23'h0;
      r_data_in  <= 32'h0;
      r_err      <= 1'b0;
    end else begin
      r_we       <= w_we_nxt;
      r_sel      <= w_sel_nxt;
      r_wr_data  <= w_wr_data_nxt;
      r_rd_data  <= w_rd_data_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ack      <= w_ack_nxt;
      r_dat_o    <= w_dat_o_nxt;
      r_in_valid <= w_in_valid_nxt;
      r_rw       <= w_rw_nxt;
      r_addr     <= w_addr_nxt;
      r_data_in  <= w_data_in_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign wbs_ack_o   = r_ack;
  assign wbs_dat_o   = r_dat_o;
  assign sd_in_valid = r_in_valid;
  assign sd_rw       = r_rw;
  assign sd_addr     = r_addr;
  assign sd_data_in  = r_data_in;
  assign err_o       = r_err;

endmodule

// File: tb/tb_wb_sdram_bridge.sv
// Bench for wb_sdram_bridge: a behavioural SDRAM controller model plus a
// word-level reference memory, directed corner cases and a random phase.
module tb_wb_sdram_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        sd_in_valid, sd_rw;
  logic [22:0] sd_addr;
  logic [31:0] sd_data_in;
  logic        sd_busy;
  logic        sd_out_valid = 1'b0;
  logic [31:0] sd_data_out  = 32'h0;
  logic        err_o;

  wb_sdram_bridge dut (
    .clk(clk), .rst_n(rst_n),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .sd_in_valid(sd_in_valid), .sd_rw(sd_rw), .sd_addr(sd_addr),
    .sd_data_in(sd_data_in), .sd_busy(sd_busy), .sd_out_valid(sd_out_valid),
    .sd_data_out(sd_data_out), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int cyc_no = 0;
  always @(posedge clk) cyc_no <= cyc_no + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---------------- controller model ----------------
  logic [31:0] mem [int];
  int   lat_cfg = 2, busy_extra = 0, busy_cnt = 0, rd_cd = 0;
  bit   busy_force = 0, noresp = 0;
  int   n_pulses = 0, viol = 0, last_samp = 0, ov_samp = 0;
  logic last_rw;
  logic [22:0] last_addr;
  logic [31:0] last_data, rd_val;
  logic s_v, s_rw, s_rst, s_busy = 1'b0, s_busy_prev = 1'b0;
  logic [22:0] s_addr;
  logic [31:0] s_dat;

  assign sd_busy = busy_force | (busy_cnt != 0);

  always begin
    @(posedge clk);
    s_v = sd_in_valid; s_rw = sd_rw; s_addr = sd_addr; s_dat = sd_data_in; s_rst = rst_n;
    s_busy_prev = s_busy; s_busy = sd_busy;
    #1;
    if (!s_rst) begin
      rd_cd = 0; busy_cnt = 0;
    end else if (s_v) begin
      n_pulses++;
      if (s_busy_prev) viol++;
      last_rw = s_rw; last_addr = s_addr; last_data = s_dat; last_samp = cyc_no;
      if (s_rw) mem[int'(s_addr)] = s_dat;
      else begin
        rd_cd  = lat_cfg;
        rd_val = mem.exists(int'(s_addr)) ? mem[int'(s_addr)] : 32'h0;
      end
      busy_cnt = busy_extra;
    end else if (busy_cnt > 0) busy_cnt--;
    sd_out_valid = 1'b0;
    sd_data_out  = $urandom;
    if (rd_cd > 0) begin
      rd_cd--;
      if (rd_cd == 0 && !noresp) begin
        sd_out_valid = 1'b1;
        sd_data_out  = rd_val;
        ov_samp      = cyc_no + 1;
      end
    end
  end

  // ---------------- bus master ----------------
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                         input logic [31:0] dat, input int budget,
                         output logic [31:0] rd, output logic got, output int lat, output int ae);
    got = 1'b0; lat = -1; rd = 32'h0; ae = -1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_sel_i = sel; wbs_adr_i = adr; wbs_dat_i = dat;
    for (int n = 0; n < budget; n++) begin
      @(posedge clk); #1;
      if (wbs_ack_o) begin
        got = 1'b1; lat = n; rd = wbs_dat_o; ae = cyc_no;
        break;
      end
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    @(posedge clk); #1;
    if (got) chk("ack_one_cycle", wbs_ack_o, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_ack"},  wbs_ack_o,   0);
    chk({pfx, "_dat"},  wbs_dat_o,   0);
    chk({pfx, "_iv"},   sd_in_valid, 0);
    chk({pfx, "_rw"},   sd_rw,       0);
    chk({pfx, "_addr"}, sd_addr,     0);
    chk({pfx, "_din"},  sd_data_in,  0);
    chk({pfx, "_err"},  err_o,       0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, ref_mem [8], mask, dat, adr;
    logic        got, we;
    logic [3:0]  sel;
    int          lat, ae, p0, rel, w;

    rst_n = 1'b0;
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_sel_i = 0; wbs_adr_i = 0; wbs_dat_i = 0;
    repeat (3) @(posedge clk); #1;
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // full write, controller idle
    p0 = n_pulses;
    wb_xfer(1, 32'h3800_0010, 4'hF, 32'h1234_5678, 50, rd, got, lat, ae);
    chk("fw_ack", got, 1);
    chk("fw_lat", lat, 2);
    chk("fw_pulses", n_pulses - p0, 1);
    chk("fw_rw", last_rw, 1);
    chk("fw_addr", last_addr, 4);
    chk("fw_data", last_data, 32'h1234_5678);

    // read back
    lat_cfg = 3; p0 = n_pulses;
    wb_xfer(0, 32'h3800_0010, 4'hF, 32'h0, 50, rd, got, lat, ae);
    chk("rd_ack", got, 1);
    chk("rd_data", rd, 32'h1234_5678);
    chk("rd_rw", last_rw, 0);
    chk("rd_pulses", n_pulses - p0, 1);
    chk("rd_ack_after_ov", ae - ov_samp, 1);

    // partial write -> read-modify-write
    p0 = n_pulses;
    wb_xfer(1, 32'h3800_0010, 4'b0010, 32'h0000_AB00, 50, rd, got, lat, ae);
    chk("pw_ack", got, 1);
    chk("pw_pulses", n_pulses - p0, 2);
    chk("pw_rw", last_rw, 1);
    chk("pw_addr", last_addr, 4);
    chk("pw_data", last_data, 32'h1234_AB78);

    // busy held for 20 cycles
    p0 = n_pulses; rel = 0;
    fork
      begin
        busy_force = 1;
        wb_xfer(0, 32'h3800_0010, 4'hF, 32'h0, 100, rd, got, lat, ae);
      end
      begin
        repeat (20) @(posedge clk);
        #1 busy_force = 0;
        rel = cyc_no;
      end
    join
    chk("busy_ack", got, 1);
    chk("busy_data", rd, 32'h1234_AB78);
    chk("busy_first_pulse", last_samp - rel, 2);
    chk("busy_pulses", n_pulses - p0, 1);
    chk("busy_violations", viol, 0);

    // read timeout
    noresp = 1;
    wb_xfer(0, 32'h3800_0030, 4'hF, 32'h0, 1100, rd, got, lat, ae);
    noresp = 0;
    chk("to_ack", got, 1);
    chk("to_data", rd, 32'hDEAD_BEEF);
    chk("to_ack_edge", ae - last_samp, 1023);
    chk("to_err", err_o, 1);

    // normal read afterwards: error flag stays set
    wb_xfer(0, 32'h3800_0010, 4'hF, 32'h0, 50, rd, got, lat, ae);
    chk("post_to_data", rd, 32'h1234_AB78);
    chk("err_sticky", err_o, 1);

    // out-of-window accesses
    p0 = n_pulses;
    wb_xfer(0, 32'h3000_0000, 4'hF, 32'h0, 12, rd, got, lat, ae);
    chk("miss_rd_ack", got, 0);
    wb_xfer(1, 32'h3000_0000, 4'hF, 32'h5555_AAAA, 12, rd, got, lat, ae);
    chk("miss_wr_ack", got, 0);
    chk("miss_pulses", n_pulses - p0, 0);

    // reset during RD_WAIT
    noresp = 1;
    fork
      wb_xfer(0, 32'h3800_0020, 4'hF, 32'h0, 40, rd, got, lat, ae);
      begin
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        chk_reset_outputs("midrst");
        repeat (45) @(posedge clk);
        #1 rst_n = 1'b1;
      end
    join
    noresp = 0;
    chk("midrst_no_ack", got, 0);
    @(posedge clk); #1;

    // random traffic against a word-level reference memory
    for (int i = 0; i < 8; i++) ref_mem[i] = 32'h0;
    for (int t = 0; t < 60; t++) begin
      w   = int'($urandom_range(0, 7));
      adr = 32'h3800_0040 + 32'(w * 4);
      we  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       sel = 4'hF;
        1:       sel = 4'h0;
        default: sel = 4'($urandom_range(0, 15));
      endcase
      dat = $urandom;
      lat_cfg = int'($urandom_range(1, 6));
      busy_extra = int'($urandom_range(0, 3));
      p0 = n_pulses;
      wb_xfer(we, adr, sel, dat, 200, rd, got, lat, ae);
      chk("rnd_ack", got, 1);
      if (!we) begin
        chk("rnd_rd_data", rd, ref_mem[w]);
        chk("rnd_rd_pulses", n_pulses - p0, 1);
      end else if (sel == 4'hF) begin
        ref_mem[w] = dat;
        chk("rnd_fw_pulses", n_pulses - p0, 1);
      end else if (sel == 4'h0) begin
        chk("rnd_nw_pulses", n_pulses - p0, 0);
        chk("rnd_nw_lat", lat, 1);
      end else begin
        mask = 32'h0;
        for (int b = 0; b < 4; b++) if (sel[b]) mask = mask | (32'hFF << (8 * b));
        ref_mem[w] = (ref_mem[w] & ~mask) | (dat & mask);
        chk("rnd_pw_pulses", n_pulses - p0, 2);
      end
    end
    for (int i = 0; i < 8; i++)
      chk("rnd_mem", mem.exists(16 + i) ? mem[16 + i] : 32'h0, ref_mem[i]);
    chk("rnd_busy_violations", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
